// File: rtl/alu_issue.sv
// Decode->execute issue stage with a 2-entry skid buffer, ALU operand build and alusel decode.
// Optional build macro ISSUE_PERF_EN adds issued/stall performance counters.
module alu_issue #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [AWIDTH-1:0] pc_i,
   input  logic [DWIDTH-1:0] rs1_i,
   input  logic [DWIDTH-1:0] rs2_i,
   input  logic [DWIDTH-1:0] imm_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic              flush_i,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] rs1_o,
   output logic [DWIDTH-1:0] rs2_o,
   output logic [6:0]        opcode_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [3:0]        alusel_o,
   output logic              illegal_o
`ifdef ISSUE_PERF_EN
   ,
   output logic [31:0]       issued_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_XOR  = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SRA  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_PASS = 4'd8;

   localparam logic [6:0] OP_OPCODE     = 7'b0110011;
   localparam logic [6:0] OPIMM_OPCODE  = 7'b0010011;
   localparam logic [6:0] LOAD_OPCODE   = 7'b0000011;
   localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
   localparam logic [6:0] JALR_OPCODE   = 7'b1100111;
   localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
   localparam logic [6:0] LUI_OPCODE    = 7'b0110111;
   localparam logic [6:0] AUIPC_OPCODE  = 7'b0010111;
   localparam logic [6:0] JAL_OPCODE    = 7'b1101111;

   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [DWIDTH-1:0] a;
      logic [DWIDTH-1:0] b;
      logic [6:0]        opcode;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [3:0]        alusel;
      logic              illegal;
   } entry_t;

   function automatic logic [3:0] f3_sel(input logic [2:0] f3, input logic is_r, input logic f7_5);
      case (f3)
         3'b000:  f3_sel = (is_r & f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  f3_sel = ALU_SLL;
         3'b010:  f3_sel = ALU_SUB;
         3'b011:  f3_sel = ALU_SUB;
         3'b100:  f3_sel = ALU_XOR;
         3'b101:  f3_sel = f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  f3_sel = ALU_OR;
         3'b111:  f3_sel = ALU_AND;
         default: f3_sel = ALU_ADD;
      endcase
   endfunction

   function automatic entry_t decode(input logic [AWIDTH-1:0] pc, input logic [DWIDTH-1:0] rs1,
                                     input logic [DWIDTH-1:0] rs2, input logic [DWIDTH-1:0] imm,
                                     input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      entry_t e;
      e.pc      = pc;
      e.a       = rs1;
      e.b       = imm;
      e.opcode  = op;
      e.funct3  = f3;
      e.funct7  = f7;
      e.alusel  = ALU_ADD;
      e.illegal = 1'b0;
      case (op)
         OP_OPCODE: begin
            e.b      = rs2;
            e.alusel = f3_sel(f3, 1'b1, f7[5]);
         end
         OPIMM_OPCODE: begin
            e.alusel = f3_sel(f3, 1'b0, f7[5]);
            // Shift-immediates only use the low five bits as the shift amount.
            e.b = (f3 == 3'b001 || f3 == 3'b101) ? {{(DWIDTH-5){1'b0}}, imm[4:0]} : imm;
         end
         LOAD_OPCODE, STORE_OPCODE, JALR_OPCODE, BRANCH_OPCODE: e.alusel = ALU_ADD;
         LUI_OPCODE:   e.alusel = ALU_PASS;
         AUIPC_OPCODE, JAL_OPCODE: begin
            e.a      = DWIDTH'(pc);
            e.alusel = ALU_ADD;
         end
         default: begin
            e.b       = {DWIDTH{1'b0}};
            e.alusel  = ALU_PASS;
            e.illegal = 1'b1;
         end
      endcase
      return e;
   endfunction

   entry_t main_q, main_d, skid_q, skid_d, dec_s;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   accept_s, issue_s;

   assign dec_s    = decode(pc_i, rs1_i, rs2_i, imm_i, opcode_i, funct3_i, funct7_i);
   assign accept_s = in_valid_i & ~skid_valid_q;
   assign issue_s  = main_valid_q & ex_ready_i;

   // Skid-buffer next state; flush wins over both issue and accept.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         main_valid_d = accept_s;
         main_d       = accept_s ? dec_s : main_q;
      end else if (issue_s) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = accept_s;
            main_d       = accept_s ? dec_s : main_q;
         end
      end else begin
         skid_valid_d = skid_valid_q | accept_s;
         skid_d       = accept_s ? dec_s : skid_q;
      end
   end

   // Entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready_o = ~skid_valid_q;
   assign ex_valid_o = main_valid_q;
   assign pc_o       = main_q.pc;
   assign rs1_o      = main_q.a;
   assign rs2_o      = main_q.b;
   assign opcode_o   = main_q.opcode;
   assign funct3_o   = main_q.funct3;
   assign funct7_o   = main_q.funct7;
   assign alusel_o   = main_q.alusel;
   assign illegal_o  = main_valid_q & main_q.illegal;

`ifdef ISSUE_PERF_EN
   logic [31:0] issued_cnt_q, stall_cnt_q;

   // Performance counters; free-running, untouched by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_cnt_q <= 32'd0;
         stall_cnt_q  <= 32'd0;
      end else begin
         issued_cnt_q <= issued_cnt_q + {31'd0, issue_s};
         stall_cnt_q  <= stall_cnt_q + {31'd0, main_valid_q & ~ex_ready_i};
      end
   end

   assign issued_cnt_o = issued_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed table, hand-written handshake sequences, random vs queue model.
module tb_alu_issue;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_XOR = 4'd3,
                          ALU_SRL = 4'd4, ALU_SRA = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7, ALU_PASS = 4'd8;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] pc, rs1, rs2, imm;
   } op_t;

   typedef struct {
      op_t         o;
      logic [31:0] a, b;
      logic [3:0]  sel;
      logic        ill;
      logic        chk_a;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, ex_valid, ex_ready, illegal_o;
   logic [31:0] pc, rs1, rs2, imm, pc_o, rs1_o, rs2_o;
   logic [6:0]  opcode, funct7, opcode_o, funct7_o;
   logic [2:0]  funct3, funct3_o;
   logic [3:0]  alusel_o;
`ifdef ISSUE_PERF_EN
   logic [31:0] issued_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   alu_issue #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .pc_i(pc), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
      .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .flush_i(flush),
      .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
      .alusel_o(alusel_o), .illegal_o(illegal_o)
`ifdef ISSUE_PERF_EN
      , .issued_cnt_o(issued_cnt), .stall_cnt_o(stall_cnt)
`endif
   );

   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t q[$];
   int   m_issued = 0;
   int   m_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference decode straight from the instruction-class rules.
   function automatic exp_t ref_decode(input op_t o);
      exp_t e;
      logic is_r, is_i;
      e.o = o; e.a = o.rs1; e.b = o.imm; e.sel = ALU_ADD; e.ill = 1'b0; e.chk_a = 1'b1;
      is_r = (o.op == 7'h33);
      is_i = (o.op == 7'h13);
      if (is_r || is_i) begin
         if (is_r) e.b = o.rs2;
         if (o.f3 == 3'd0) e.sel = (is_r && o.f7 == 7'h20) ? ALU_SUB :
                                   ((is_r && o.f7[5]) ? ALU_SUB : ALU_ADD);
         else if (o.f3 == 3'd1) e.sel = ALU_SLL;
         else if (o.f3 == 3'd2 || o.f3 == 3'd3) e.sel = ALU_SUB;
         else if (o.f3 == 3'd4) e.sel = ALU_XOR;
         else if (o.f3 == 3'd5) e.sel = o.f7[5] ? ALU_SRA : ALU_SRL;
         else if (o.f3 == 3'd6) e.sel = ALU_OR;
         else e.sel = ALU_AND;
         if (is_i && (o.f3 == 3'd1 || o.f3 == 3'd5)) e.b = o.imm % 32'd32;
      end else if (o.op == 7'h37) begin
         e.sel = ALU_PASS; e.chk_a = 1'b0;
      end else if (o.op == 7'h17 || o.op == 7'h6F) begin
         e.a = o.pc;
      end else if (!(o.op == 7'h03 || o.op == 7'h23 || o.op == 7'h67 || o.op == 7'h63)) begin
         e.sel = ALU_PASS; e.b = 32'd0; e.ill = 1'b1; e.chk_a = 1'b0;
      end
      return e;
   endfunction

   function automatic op_t mk_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] i);
      op_t o;
      o.op = op; o.f3 = f3; o.f7 = f7; o.pc = p; o.rs1 = a; o.rs2 = b; o.imm = i;
      return o;
   endfunction

   function automatic exp_t mk_vec(input op_t o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] sel, input logic ill);
      exp_t e;
      e.o = o; e.a = a; e.b = b; e.sel = sel; e.ill = ill; e.chk_a = 1'b1;
      return e;
   endfunction

   task automatic drive(input op_t o, input logic v);
      in_valid = v; opcode = o.op; funct3 = o.f3; funct7 = o.f7;
      pc = o.pc; rs1 = o.rs1; rs2 = o.rs2; imm = o.imm;
   endtask

   // One clock: advance the queue model with the current inputs, then return at the falling edge.
   task automatic tick();
      logic iss, acc;
      op_t  cur;
      cur = mk_op(opcode, funct3, funct7, pc, rs1, rs2, imm);
      iss = (q.size() > 0) && ex_ready;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0) begin
         if (ex_ready) m_issued++;
         else m_stall++;
      end
      if (flush) q.delete();
      else begin
         if (iss) void'(q.pop_front());
         if (acc) q.push_back(ref_decode(cur));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic compare_model(input string tag);
      exp_t e;
      chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(q.size() > 0));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         e = q[0];
         chk({tag, ".pc"}, pc_o, e.o.pc);
         chk({tag, ".opcode"}, 32'(opcode_o), 32'(e.o.op));
         chk({tag, ".funct3"}, 32'(funct3_o), 32'(e.o.f3));
         chk({tag, ".funct7"}, 32'(funct7_o), 32'(e.o.f7));
         chk({tag, ".opB"}, rs2_o, e.b);
         chk({tag, ".alusel"}, 32'(alusel_o), 32'(e.sel));
         chk({tag, ".illegal"}, 32'(illegal_o), 32'(e.ill));
         if (e.chk_a) chk({tag, ".opA"}, rs1_o, e.a);
      end else begin
         chk({tag, ".illegal_idle"}, 32'(illegal_o), 32'd0);
      end
   endtask

   task automatic check_vec(input int n, input exp_t v);
      string t;
      t = $sformatf("tbl%0d", n);
      chk({t, ".ex_valid"}, 32'(ex_valid), 32'd1);
      chk({t, ".pc"}, pc_o, v.o.pc);
      chk({t, ".opA"}, rs1_o, v.a);
      chk({t, ".opB"}, rs2_o, v.b);
      chk({t, ".alusel"}, 32'(alusel_o), 32'(v.sel));
      chk({t, ".illegal"}, 32'(illegal_o), 32'(v.ill));
      chk({t, ".opcode"}, 32'(opcode_o), 32'(v.o.op));
      chk({t, ".funct7"}, 32'(funct7_o), 32'(v.o.f7));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      m_issued = 0;
      m_stall = 0;
   endtask

   exp_t        tbl[19];
   op_t         oa, ob, oc, od;
   logic [6:0]  op_pool[10];

   initial begin
      tbl[0]  = mk_vec(mk_op(7'h33, 3'd0, 7'h00, 32'h100, 32'd5, 32'd7, 32'h99), 32'd5, 32'd7, ALU_ADD, 1'b0);
      tbl[1]  = mk_vec(mk_op(7'h33, 3'd0, 7'h20, 32'h104, 32'd10, 32'd3, 32'h99), 32'd10, 32'd3, ALU_SUB, 1'b0);
      tbl[2]  = mk_vec(mk_op(7'h13, 3'd5, 7'h20, 32'h108, 32'h80000000, 32'h77, 32'h405), 32'h80000000, 32'd5, ALU_SRA, 1'b0);
      tbl[3]  = mk_vec(mk_op(7'h37, 3'd0, 7'h00, 32'h10C, 32'd0, 32'h77, 32'h12345000), 32'd0, 32'h12345000, ALU_PASS, 1'b0);
      tbl[4]  = mk_vec(mk_op(7'h17, 3'd3, 7'h00, 32'h1000, 32'h55, 32'h66, 32'h2000), 32'h1000, 32'h2000, ALU_ADD, 1'b0);
      tbl[5]  = mk_vec(mk_op(7'h7F, 3'd0, 7'h00, 32'h110, 32'd0, 32'h44, 32'h66), 32'd0, 32'd0, ALU_PASS, 1'b1);
      tbl[6]  = mk_vec(mk_op(7'h13, 3'd0, 7'h20, 32'h114, 32'd9, 32'h44, 32'hFFFFFFFF), 32'd9, 32'hFFFFFFFF, ALU_ADD, 1'b0);
      tbl[7]  = mk_vec(mk_op(7'h13, 3'd2, 7'h00, 32'h118, 32'd3, 32'd0, 32'h10), 32'd3, 32'h10, ALU_SUB, 1'b0);
      tbl[8]  = mk_vec(mk_op(7'h63, 3'd1, 7'h00, 32'h11C, 32'h20, 32'h30, 32'hFFFFFFF8), 32'h20, 32'hFFFFFFF8, ALU_ADD, 1'b0);
      tbl[9]  = mk_vec(mk_op(7'h33, 3'd5, 7'h00, 32'h120, 32'h40, 32'd3, 32'h7), 32'h40, 32'd3, ALU_SRL, 1'b0);
      tbl[10] = mk_vec(mk_op(7'h13, 3'd1, 7'h00, 32'h124, 32'd1, 32'h9, 32'hFFF), 32'd1, 32'h1F, ALU_SLL, 1'b0);
      tbl[11] = mk_vec(mk_op(7'h6F, 3'd0, 7'h00, 32'h400, 32'd9, 32'd8, 32'h10), 32'h400, 32'h10, ALU_ADD, 1'b0);
      tbl[12] = mk_vec(mk_op(7'h23, 3'd2, 7'h00, 32'h128, 32'h80, 32'h5, 32'd8), 32'h80, 32'd8, ALU_ADD, 1'b0);
      tbl[13] = mk_vec(mk_op(7'h33, 3'd7, 7'h00, 32'h12C, 32'hF0, 32'h3C, 32'h1), 32'hF0, 32'h3C, ALU_AND, 1'b0);
      tbl[14] = mk_vec(mk_op(7'h13, 3'd6, 7'h00, 32'h130, 32'h1, 32'h2, 32'h700), 32'h1, 32'h700, ALU_OR, 1'b0);
      tbl[15] = mk_vec(mk_op(7'h33, 3'd4, 7'h00, 32'h134, 32'hA, 32'h5, 32'h0), 32'hA, 32'h5, ALU_XOR, 1'b0);
      tbl[16] = mk_vec(mk_op(7'h67, 3'd0, 7'h00, 32'h138, 32'h200, 32'h5, 32'h4), 32'h200, 32'h4, ALU_ADD, 1'b0);
      tbl[17] = mk_vec(mk_op(7'h03, 3'd4, 7'h00, 32'h13C, 32'h300, 32'h5, 32'hC), 32'h300, 32'hC, ALU_ADD, 1'b0);
      tbl[18] = mk_vec(mk_op(7'h33, 3'd3, 7'h20, 32'h140, 32'h6, 32'h8, 32'h1), 32'h6, 32'h8, ALU_SUB, 1'b0);
      op_pool = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};

      drive(mk_op(7'h00, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0), 1'b0);
      flush = 1'b0; ex_ready = 1'b0;
      do_reset();
      repeat (2) @(negedge clk);
      chk("rst.ex_valid", 32'(ex_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.pc", pc_o, 32'd0);
      chk("rst.opA", rs1_o, 32'd0);
      chk("rst.opB", rs2_o, 32'd0);
      chk("rst.alusel", 32'(alusel_o), 32'd0);
      chk("rst.illegal", 32'(illegal_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed decode table: one op at a time, accepted then checked one cycle later.
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].o, 1'b1);
         ex_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         check_vec(i, tbl[i]);
         tick();
         chk($sformatf("tbl%0d.drained", i), 32'(ex_valid), 32'd0);
      end

      // Three back-to-back ops with a two-cycle execute stall.
      oa = mk_op(7'h33, 3'd0, 7'h00, 32'h200, 32'h111, 32'h1, 32'h0);
      ob = mk_op(7'h33, 3'd0, 7'h00, 32'h204, 32'h222, 32'h2, 32'h0);
      oc = mk_op(7'h33, 3'd0, 7'h00, 32'h208, 32'h333, 32'h3, 32'h0);
      ex_ready = 1'b0;
      drive(oa, 1'b1); tick();
      chk("b2b.rdy1", 32'(in_ready), 32'd1);
      chk("b2b.A_out", rs1_o, 32'h111);
      drive(ob, 1'b1); tick();
      chk("b2b.rdy_low", 32'(in_ready), 32'd0);
      chk("b2b.A_hold", rs1_o, 32'h111);
      drive(oc, 1'b1); tick();
      chk("b2b.rdy_low2", 32'(in_ready), 32'd0);
      chk("b2b.A_stable", rs1_o, 32'h111);
      compare_model("b2b.s2");
      ex_ready = 1'b1; tick();
      chk("b2b.B_out", rs1_o, 32'h222);
      chk("b2b.rdy_back", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b.C_out", rs1_o, 32'h333);
      chk("b2b.C_pc", pc_o, 32'h208);
      tick();
      chk("b2b.empty", 32'(ex_valid), 32'd0);

      // Flush with both entries full and an incoming op.
      ex_ready = 1'b0;
      drive(oa, 1'b1); tick();
      drive(ob, 1'b1); tick();
      chk("fl.full", 32'(in_ready), 32'd0);
      drive(oc, 1'b1); flush = 1'b1; ex_ready = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl.ex_valid", 32'(ex_valid), 32'd0);
      chk("fl.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("fl.stays_empty", 32'(ex_valid), 32'd0);
      // Flush with room: incoming accept and issue both overridden.
      ex_ready = 1'b0;
      drive(oa, 1'b1); tick();
      drive(ob, 1'b1); flush = 1'b1; ex_ready = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl2.ex_valid", 32'(ex_valid), 32'd0);
      chk("fl2.in_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset with a valid op present.
      ex_ready = 1'b0;
      drive(oc, 1'b1); tick();
      in_valid = 1'b0;
      chk("arst.pre", 32'(ex_valid), 32'd1);
      #2;
      do_reset();
      #1;
      chk("arst.ex_valid", 32'(ex_valid), 32'd0);
      chk("arst.opA", rs1_o, 32'd0);
      chk("arst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 4 issues and 3 stall cycles.
      od = mk_op(7'h13, 3'd0, 7'h00, 32'h300, 32'h4, 32'h0, 32'h1);
      drive(oa, 1'b1); ex_ready = 1'b0; tick();
      in_valid = 1'b0; tick(); tick(); tick();
      ex_ready = 1'b1;
      drive(ob, 1'b1); tick();
      drive(oc, 1'b1); tick();
      drive(od, 1'b1); tick();
      in_valid = 1'b0; tick();
      chk("perf.drained", 32'(ex_valid), 32'd0);
`ifdef ISSUE_PERF_EN
      chk("perf.issued", issued_cnt, 32'd4);
      chk("perf.stall", stall_cnt, 32'd3);
`endif

      // Randomized traffic against the queue model.
      for (int c = 0; c < 600; c++) begin
         compare_model($sformatf("rnd%0d", c));
         oa = mk_op(($urandom_range(0, 9) == 9) ? 7'($urandom) : op_pool[$urandom_range(0, 9)],
                    3'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00),
                    $urandom, $urandom, $urandom, $urandom);
         drive(oa, ($urandom_range(0, 3) != 0));
         ex_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         tick();
      end
      flush = 1'b0;
      compare_model("rnd.end");
`ifdef ISSUE_PERF_EN
      chk("perf.rnd_issued", issued_cnt, 32'(m_issued));
      chk("perf.rnd_stall", stall_cnt, 32'(m_stall));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
